// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and helpers for the multiplexed 7-segment scanner.
//
// Contents:
//   NUM_DIGITS, CODE_W, IDX_W    : display geometry (8 digits of 4-bit codes)
//   SCAN_DIV_DEF, DEAD_DEF,
//   BLINK_BIT_DEF                : default parameter values for seg_scan/seg_tick
//   LED_OFF                      : active-low digit-select pattern with every digit dark
//   digit_idx_t                  : index type for the currently scanned digit
//   digit_select()               : active-low one-hot select for a digit index
package seg_pkg;

    localparam int NUM_DIGITS    = 8;
    localparam int CODE_W        = 4;
    localparam int IDX_W         = 3;

    localparam int SCAN_DIV_DEF  = 50000;
    localparam int DEAD_DEF      = 16;
    localparam int BLINK_BIT_DEF = 7;

    localparam logic [NUM_DIGITS-1:0] LED_OFF = 8'hFF;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Active-low select: only the bit of the addressed digit is driven low.
    function automatic logic [NUM_DIGITS-1:0] digit_select(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_tick.sv
// seg_tick -- slot timer for the digit scanner.
//
// Counts clk cycles inside one digit slot (0..SCAN_DIV-1) and reports the
// last cycle of the slot and whether the slot is still in its dead time.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous reset, active-low
//   tick  out  high on the last cycle of a slot (cnt == SCAN_DIV-1)
//   dead  out  high while cnt < DEAD (all digits must stay dark)
module seg_tick
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int DEAD     = DEAD_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic dead
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_V  = CNT_W'(DEAD);

    logic [CNT_W-1:0] cnt;

    // Free-running slot counter; the wrap on tick keeps every slot exactly
    // SCAN_DIV cycles long, independent of anything else in the design.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);
    assign dead = (cnt < DEAD_V);

endmodule

// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed scanner for an 8-digit 7-segment display.
//
// Each digit gets a slot of SCAN_DIV clocks; the first DEAD clocks of a slot
// keep every digit dark to avoid ghosting. Display data is held in shadow
// registers that only change at a frame boundary, so a frame is never torn.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   digits      in   eight 4-bit codes, nibble i belongs to digit i
//   digit_on    in   per-digit display enable
//   blink_mask  in   per-digit blink select (used only with SEG_SCAN_BLINK_EN)
//   upd         in   one-cycle request to take digits/digit_on at the next frame boundary
//   led_en      out  active-low digit selects (one-hot-low or all ones)
//   num_set     out  code of the active digit for the segment encoder
//   frame_done  out  one-cycle pulse after each frame wrap
//
// Build option:
//   SEG_SCAN_BLINK_EN  when defined, an 8-bit frame counter is built and
//                      digits selected by blink_mask go dark whenever
//                      frame-counter bit BLINK_BIT is set.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int DEAD      = DEAD_DEF,
    parameter int BLINK_BIT = BLINK_BIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_DIGITS*CODE_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]        digit_on,
    input  logic [NUM_DIGITS-1:0]        blink_mask,
    input  logic                         upd,
    output logic [NUM_DIGITS-1:0]        led_en,
    output logic [CODE_W-1:0]            num_set,
    output logic                         frame_done
);

    logic                         tick;
    logic                         dead;
    digit_idx_t                   idx;
    logic                         pend;
    logic [NUM_DIGITS*CODE_W-1:0] sh_dig;
    logic [NUM_DIGITS-1:0]        sh_on;
    logic                         frame_wrap;
    logic                         blinked;
    logic                         dark;
    logic [CODE_W-1:0]            cur_code;

    seg_tick #(
        .SCAN_DIV (SCAN_DIV),
        .DEAD     (DEAD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .dead (dead)
    );

    // The last cycle of the last slot is the frame boundary.
    assign frame_wrap = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + digit_idx_t'(1);
        end
    end

    // An upd landing exactly on the boundary is honoured immediately, so pend
    // is cleared rather than set in that cycle. Repeated upd while pending
    // changes nothing: the live inputs are sampled at the boundary anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= 1'b0;
            sh_dig <= '0;
            sh_on  <= '0;
        end else if (frame_wrap) begin
            if (pend || upd) begin
                sh_dig <= digits;
                sh_on  <= digit_on;
            end
            pend <= 1'b0;
        end else if (upd) begin
            pend <= 1'b1;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    logic [7:0] fcnt;

    // Frame counter advances once per frame and wraps freely; its BLINK_BIT
    // sets the blink phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= '0;
        end else if (frame_wrap) begin
            fcnt <= fcnt + 8'd1;
        end
    end

    assign blinked = fcnt[BLINK_BIT] && blink_mask[idx];
`else
    localparam int unused_blink_bit = BLINK_BIT;
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blinked           = 1'b0;
`endif

    assign dark     = dead || !sh_on[idx] || blinked;
    assign cur_code = sh_dig[{idx, 2'b00} +: CODE_W];

    // Output stage: one cycle behind (idx, cnt), which keeps the pins
    // glitch-free and lets frame_done line up as a clean single pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_en     <= LED_OFF;
            num_set    <= '0;
            frame_done <= 1'b0;
        end else begin
            led_en     <= dark ? LED_OFF : digit_select(idx);
            num_set    <= cur_code;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000; clk cycles per digit slot, legal range >= 4.
REQ-002 Parameter DEAD, default 16; leading cycles of each slot with all digits off, legal range 1..SCAN_DIV-2.
REQ-003 Parameter BLINK_BIT, default 7; frame-counter bit that sets the blink phase.
REQ-004 Port clk  input  1  system clock; the block's only clock.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port digits  input  32  eight 4-bit codes; nibble i belongs to digit i.
REQ-007 Port digit_on  input  8  per-digit display enable.
REQ-008 Port blink_mask  input  8  per-digit blink select.
REQ-009 Port upd  input  1  one-cycle request to take digits and digit_on.
REQ-010 Port led_en  output  8  digit selects, active-low, one-hot-low or all ones.
REQ-011 Port num_set  output  4  code of the active digit, fed to the segment encoder.
REQ-012 Port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 Slot counter cnt runs 0..SCAN_DIV-1; tick is asserted when cnt==SCAN_DIV-1; cnt wraps to 0.
REQ-014 Digit index idx (3 bits) increments on tick and wraps from 7 to 0; the wrap is the frame boundary.
REQ-015 Shadow registers sh_dig[31:0] and sh_on[7:0] drive the display; live inputs never reach the outputs directly.
REQ-016 upd sets pend; at the frame boundary, if pend==1, the shadows load from the live inputs and pend clears.
REQ-017 If upd and the frame boundary occur in the same cycle, the shadows load from the inputs sampled that cycle and pend stays 0.
REQ-018 An upd while pend==1 has no further effect; the most recent inputs are taken at the boundary.
REQ-019 Outputs are registered with one cycle of latency from (idx, cnt).
REQ-020 num_set = sh_dig[4*idx+3 : 4*idx].
REQ-021 led_en = 8'hFF when any of these holds: cnt < DEAD; sh_on[idx]==0; the digit is blinked.
REQ-022 Otherwise led_en = ~(8'b1 << idx).
REQ-023 frame_done is registered and pulses high for exactly one cycle, on the cycle after idx wraps from 7 to 0.
REQ-024 Frame period is 8*SCAN_DIV clk cycles, independent of upd.

Reset
REQ-025 While rst==0: cnt=0, idx=0, pend=0, sh_dig=0, sh_on=0, frame counter=0.
REQ-026 While rst==0: led_en=8'hFF, num_set=0, frame_done=0.
REQ-027 Reset asserted mid-slot or mid-frame forces this state immediately, without waiting for a clock edge.
REQ-028 After release, the first slot starts at idx=0 with its full dead-time.

Configuration
REQ-029 Macro SEG_SCAN_BLINK_EN defined: an 8-bit frame counter increments on every frame boundary and wraps.
REQ-030 With SEG_SCAN_BLINK_EN, digit i is blinked when fcnt[BLINK_BIT]==1 and blink_mask[i]==1.
REQ-031 Without SEG_SCAN_BLINK_EN: no frame counter is built, blink_mask is ignored, and no digit is ever blinked.

Structure
REQ-032 Shared package seg_pkg holds: NUM_DIGITS=8, CODE_W=4, defaults for SCAN_DIV, DEAD and BLINK_BIT, and the all-off constant LED_OFF=8'hFF.
REQ-033 A single sub-module, seg_tick, contains cnt and produces tick and the dead-time flag.
REQ-034 All other logic (shadows, idx, blink, output registers) lives in seg_scan.

Verification (SCAN_DIV=4, DEAD=1, BLINK_BIT=0)
REQ-035 Reset released, upd with digits=32'h76543210 and digit_on=8'hFF -> after the next frame boundary, slot i drives num_set=i and led_en=~(1<<i) on cycles 2..4 of the slot, and 8'hFF on cycle 1.
REQ-036 digit_on=8'b1111_1110 taken via upd -> led_en stays 8'hFF throughout slot 0; slots 1..7 behave as normal.
REQ-037 upd pulsed mid-frame with digits=32'hFFFFFFFF -> num_set keeps the old values until the frame boundary, then all slots show 4'hF; frame_done pulses once per 32 cycles.
REQ-038 upd coincident with the frame boundary -> new values appear in slot 0 of the immediately following frame.
REQ-039 rst dropped at idx=5, cnt=2 -> led_en=8'hFF and num_set=0 without a clock edge; after release, idx=0 with a dead cycle first.
REQ-040 SEG_SCAN_BLINK_EN defined, blink_mask=8'h01 -> digit 0 is lit on alternate frames only; without the macro, digit 0 is lit every frame.
